// File: rtl/vx_writeback_arbiter_pkg.sv
// Shared configuration, execute-unit indices and writeback packet layout
// for the writeback arbiter and its round-robin lock arbiter.
package vx_writeback_arbiter_pkg;

  localparam int unsigned NUM_REQS      = 5;
  localparam int unsigned NUM_THREADS   = 4;
  localparam int unsigned NUM_WARPS     = 4;
  localparam int unsigned WID_W         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned NR_BITS       = 6;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned UUID_W        = 44;
  localparam int unsigned PERF_CTR_BITS = 44;
  localparam int unsigned REQ_IDX_W     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_CSR = 2;
  localparam int unsigned WB_FPU = 3;
  localparam int unsigned WB_GPU = 4;

  typedef struct packed {
    logic [UUID_W-1:0]           uuid;
    logic [WID_W-1:0]            wid;
    logic [XLEN-1:0]             PC;
    logic [NUM_THREADS-1:0]      tmask;
    logic                        wb;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        eop;
  } wb_packet_t;

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin arbiter that stays locked on one requester until it presents
// an end-of-packet grant; holds its own pointer and lock state.
module vx_rr_lock_arbiter #(
  parameter int unsigned NUM_REQS = 5,
  localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic [NUM_REQS-1:0] req_eop,
  output logic [NUM_REQS-1:0] grant_c,
  output logic [IDX_W-1:0]    grant_idx_c,
  output logic                grant_valid_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic             lock_valid;
  logic [IDX_W-1:0] lock_idx;
  logic [SUM_W-1:0] cand;

  // Locked: only the lock owner may win. Otherwise first request at or after rr_ptr.
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    cand          = '0;
    if (lock_valid) begin
      if (requests[lock_idx]) begin
        grant_valid_c = 1'b1;
        grant_idx_c   = lock_idx;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        cand = {1'b0, rr_ptr} + SUM_W'(i);
        if (cand >= SUM_W'(NUM_REQS)) begin
          cand = cand - SUM_W'(NUM_REQS);
        end
        if (!grant_valid_c && requests[cand[IDX_W-1:0]]) begin
          grant_valid_c = 1'b1;
          grant_idx_c   = cand[IDX_W-1:0];
        end
      end
    end
    if (grant_valid_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

  // Pointer advances only past a completed (eop) transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
    end else if (grant_valid_c) begin
      if (req_eop[grant_idx_c]) begin
        rr_ptr     <= (grant_idx_c == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        lock_valid <= 1'b0;
      end else begin
        lock_valid <= 1'b1;
        lock_idx   <= grant_idx_c;
      end
    end
  end

endmodule

// File: rtl/vx_writeback_arbiter.sv
// Merges execute-unit result packets into one registered writeback stream
// and counts cycles in which a writing packet had to wait.
module vx_writeback_arbiter
  import vx_writeback_arbiter_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  output logic [NUM_REQS-1:0]                  req_ready,
  input  logic [NUM_REQS*UUID_W-1:0]           req_uuid,
  input  logic [NUM_REQS*WID_W-1:0]            req_wid,
  input  logic [NUM_REQS*XLEN-1:0]             req_PC,
  input  logic [NUM_REQS*NUM_THREADS-1:0]      req_tmask,
  input  logic [NUM_REQS-1:0]                  req_wb,
  input  logic [NUM_REQS*NR_BITS-1:0]          req_rd,
  input  logic [NUM_REQS*NUM_THREADS*XLEN-1:0] req_data,
  input  logic [NUM_REQS-1:0]                  req_eop,
  output logic                                 wb_valid,
  output logic [UUID_W-1:0]                    wb_uuid,
  output logic [WID_W-1:0]                     wb_wid,
  output logic [XLEN-1:0]                      wb_PC,
  output logic [NUM_THREADS-1:0]               wb_tmask,
  output logic [NR_BITS-1:0]                   wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]          wb_data,
  output logic                                 wb_eop,
  output logic [PERF_CTR_BITS-1:0]             perf_wb_conflicts
);

  wb_packet_t             req_pkt [NUM_REQS];
  wb_packet_t             wb_q;
  logic                   valid_q;
  logic [NUM_REQS-1:0]    eligible;
  logic [NUM_REQS-1:0]    grant_c;
  logic [REQ_IDX_W-1:0]   grant_idx_c;
  logic                   grant_valid_c;

  assign eligible = req_valid & req_wb;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      req_pkt[i].uuid  = req_uuid[i*UUID_W +: UUID_W];
      req_pkt[i].wid   = req_wid[i*WID_W +: WID_W];
      req_pkt[i].PC    = req_PC[i*XLEN +: XLEN];
      req_pkt[i].tmask = req_tmask[i*NUM_THREADS +: NUM_THREADS];
      req_pkt[i].wb    = req_wb[i];
      req_pkt[i].rd    = req_rd[i*NR_BITS +: NR_BITS];
      req_pkt[i].data  = req_data[i*NUM_THREADS*XLEN +: NUM_THREADS*XLEN];
      req_pkt[i].eop   = req_eop[i];
    end
  end

  vx_rr_lock_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk           (clk),
    .reset         (reset),
    .requests      (eligible),
    .req_eop       (req_eop),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // Non-writing packets are retired immediately without taking a slot.
  assign req_ready = (req_valid & ~req_wb) | grant_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q           <= 1'b0;
      wb_q              <= '0;
      perf_wb_conflicts <= '0;
    end else begin
      valid_q <= grant_valid_c;
      if (grant_valid_c) begin
        wb_q <= req_pkt[grant_idx_c];
      end
      if (|(eligible & ~grant_c)) begin
        perf_wb_conflicts <= perf_wb_conflicts + PERF_CTR_BITS'(1);
      end
    end
  end

  // Captured packets always carry wb=1, so the AND only reflects that invariant.
  assign wb_valid = valid_q & wb_q.wb;
  assign wb_uuid  = wb_q.uuid;
  assign wb_wid   = wb_q.wid;
  assign wb_PC    = wb_q.PC;
  assign wb_tmask = wb_q.tmask;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign wb_eop   = wb_q.eop;

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Directed self-checking bench for vx_writeback_arbiter: single packet,
// round-robin wrap, eop lock, wb=0 bypass, mid-lock reset and idle hold.
module tb_vx_writeback_arbiter;
  import vx_writeback_arbiter_pkg::*;

  logic                                 clk = 1'b0;
  logic                                 reset;
  logic [NUM_REQS-1:0]                  req_valid;
  logic [NUM_REQS-1:0]                  req_ready;
  logic [NUM_REQS*UUID_W-1:0]           req_uuid;
  logic [NUM_REQS*WID_W-1:0]            req_wid;
  logic [NUM_REQS*XLEN-1:0]             req_PC;
  logic [NUM_REQS*NUM_THREADS-1:0]      req_tmask;
  logic [NUM_REQS-1:0]                  req_wb;
  logic [NUM_REQS*NR_BITS-1:0]          req_rd;
  logic [NUM_REQS*NUM_THREADS*XLEN-1:0] req_data;
  logic [NUM_REQS-1:0]                  req_eop;
  logic                                 wb_valid;
  logic [UUID_W-1:0]                    wb_uuid;
  logic [WID_W-1:0]                     wb_wid;
  logic [XLEN-1:0]                      wb_PC;
  logic [NUM_THREADS-1:0]               wb_tmask;
  logic [NR_BITS-1:0]                   wb_rd;
  logic [NUM_THREADS*XLEN-1:0]          wb_data;
  logic                                 wb_eop;
  logic [PERF_CTR_BITS-1:0]             perf_wb_conflicts;

  int total = 0;
  int bad   = 0;

  vx_writeback_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_uuid          (req_uuid),
    .req_wid           (req_wid),
    .req_PC            (req_PC),
    .req_tmask         (req_tmask),
    .req_wb            (req_wb),
    .req_rd            (req_rd),
    .req_data          (req_data),
    .req_eop           (req_eop),
    .wb_valid          (wb_valid),
    .wb_uuid           (wb_uuid),
    .wb_wid            (wb_wid),
    .wb_PC             (wb_PC),
    .wb_tmask          (wb_tmask),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .wb_eop            (wb_eop),
    .perf_wb_conflicts (perf_wb_conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic wb, input logic [NR_BITS-1:0] rd,
                         input logic [31:0] word, input logic eop,
                         input logic [NUM_THREADS-1:0] tmask);
    req_valid[idx]                                   = 1'b1;
    req_wb[idx]                                      = wb;
    req_eop[idx]                                     = eop;
    req_rd[idx*NR_BITS +: NR_BITS]                   = rd;
    req_tmask[idx*NUM_THREADS +: NUM_THREADS]        = tmask;
    req_data[idx*NUM_THREADS*XLEN +: NUM_THREADS*XLEN] = lanes(word);
    req_uuid[idx*UUID_W +: UUID_W]                   = UUID_W'(100 + idx);
    req_wid[idx*WID_W +: WID_W]                      = WID_W'(idx % 4);
    req_PC[idx*XLEN +: XLEN]                         = XLEN'(32'h1000 + idx * 4);
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_wb    = '0;
    req_eop   = '0;
    req_rd    = '0;
    req_tmask = '0;
    req_data  = '0;
    req_uuid  = '0;
    req_wid   = '0;
    req_PC    = '0;
  endtask

  initial begin
    int exp_idx;
    clear_all();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 128'(wb_valid), 128'(0));
    chk("rst_rd", 128'(wb_rd), 128'(0));
    chk("rst_data", 128'(wb_data), 128'(0));
    chk("rst_uuid", 128'(wb_uuid), 128'(0));
    chk("rst_perf", 128'(perf_wb_conflicts), 128'(0));

    // Single ALU packet
    set_req(WB_ALU, 1'b1, 6'd5, 32'h11, 1'b1, 4'hF);
    #1;
    chk("single_ready", 128'(req_ready), 128'(5'b00001));
    tick();
    clear_all();
    chk("single_valid", 128'(wb_valid), 128'(1));
    chk("single_rd", 128'(wb_rd), 128'(5));
    chk("single_data", 128'(wb_data), lanes(32'h11));
    chk("single_eop", 128'(wb_eop), 128'(1));
    chk("single_uuid", 128'(wb_uuid), 128'(100));
    chk("single_pc", 128'(wb_PC), 128'(32'h1000));
    chk("single_perf", 128'(perf_wb_conflicts), 128'(0));

    // Round-robin across all five, including wrap back to ALU
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) set_req(i, 1'b1, 6'(10 + i), 32'(i), 1'b1, 4'hF);
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_idx = k % NUM_REQS;
      chk("rr_ready", 128'(req_ready), 128'(5'b00001 << exp_idx));
      tick();
      chk("rr_rd", 128'(wb_rd), 128'(10 + exp_idx));
      chk("rr_wid", 128'(wb_wid), 128'(exp_idx % 4));
    end
    chk("rr_perf", 128'(perf_wb_conflicts), 128'(6));
    clear_all();

    // LSU lock (rr_ptr is 1): eop=0, idle bubble, eop=0, eop=1, then ALU
    set_req(WB_ALU, 1'b1, 6'd1, 32'h0, 1'b1, 4'hF);
    set_req(WB_LSU, 1'b1, 6'd2, 32'hA0, 1'b0, 4'hF);
    #1;
    chk("lock0_ready", 128'(req_ready), 128'(5'b00010));
    tick();
    chk("lock0_data", 128'(wb_data), lanes(32'hA0));
    chk("lock0_eop", 128'(wb_eop), 128'(0));
    req_valid[WB_LSU] = 1'b0;
    #1;
    chk("lock_idle_ready", 128'(req_ready), 128'(0));
    tick();
    chk("lock_idle_valid", 128'(wb_valid), 128'(0));
    chk("lock_idle_hold", 128'(wb_data), lanes(32'hA0));
    set_req(WB_LSU, 1'b1, 6'd2, 32'hA1, 1'b0, 4'hF);
    #1;
    chk("lock1_ready", 128'(req_ready), 128'(5'b00010));
    tick();
    chk("lock1_data", 128'(wb_data), lanes(32'hA1));
    set_req(WB_LSU, 1'b1, 6'd2, 32'hA2, 1'b1, 4'hF);
    #1;
    chk("lock2_ready", 128'(req_ready), 128'(5'b00010));
    tick();
    chk("lock2_data", 128'(wb_data), lanes(32'hA2));
    chk("lock2_eop", 128'(wb_eop), 128'(1));
    req_valid[WB_LSU] = 1'b0;
    #1;
    chk("unlock_ready", 128'(req_ready), 128'(5'b00001));
    tick();
    chk("unlock_rd", 128'(wb_rd), 128'(1));
    chk("lock_perf", 128'(perf_wb_conflicts), 128'(10));
    clear_all();

    // wb=0 bypass: CSR retired immediately alongside FPU grant (rr_ptr is 1)
    set_req(WB_CSR, 1'b0, 6'd3, 32'h33, 1'b1, 4'hF);
    set_req(WB_FPU, 1'b1, 6'd7, 32'h77, 1'b1, 4'hF);
    #1;
    chk("bypass_ready", 128'(req_ready), 128'(5'b01100));
    tick();
    clear_all();
    chk("bypass_valid", 128'(wb_valid), 128'(1));
    chk("bypass_rd", 128'(wb_rd), 128'(7));
    chk("bypass_data", 128'(wb_data), lanes(32'h77));
    chk("bypass_perf", 128'(perf_wb_conflicts), 128'(10));

    // Mid-lock reset (rr_ptr is 4, LSU reached via wrap)
    set_req(WB_LSU, 1'b1, 6'd3, 32'hB0, 1'b0, 4'hF);
    #1;
    chk("mid_ready", 128'(req_ready), 128'(5'b00010));
    tick();
    chk("mid_eop", 128'(wb_eop), 128'(0));
    clear_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 128'(wb_valid), 128'(0));
    chk("mid_rst_perf", 128'(perf_wb_conflicts), 128'(0));
    set_req(WB_ALU, 1'b1, 6'd9, 32'hC0, 1'b1, 4'h0);
    #1;
    chk("post_rst_ready", 128'(req_ready), 128'(5'b00001));
    tick();
    clear_all();
    chk("post_rst_valid", 128'(wb_valid), 128'(1));
    chk("post_rst_rd", 128'(wb_rd), 128'(9));
    chk("tmask0_pass", 128'(wb_tmask), 128'(0));

    // Idle: outputs hold, counter frozen
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_valid", 128'(wb_valid), 128'(0));
      chk("idle_rd", 128'(wb_rd), 128'(9));
    end
    chk("idle_data", 128'(wb_data), lanes(32'hC0));
    chk("idle_perf", 128'(perf_wb_conflicts), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
